// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: one shared 4-bit ripple slice processes an operand pair over NIBBLES cycles.
// Optional subtract mode (op_sub port) is built when NIBBLE_SERIAL_SUB_EN is defined.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [3:0]      slice_a;
  logic [3:0]      slice_b;
  logic [3:0]      slice_sum;
  logic            slice_cout;
  logic [W-1:0]    b_in;
  logic            carry_in;

  // Operand conditioning at the handshake: subtract is A + ~B + 1.
`ifdef NIBBLE_SERIAL_SUB_EN
  assign b_in     = op_sub ? ~B : B;
  assign carry_in = op_sub ? 1'b1 : Cin;
`else
  assign b_in     = B;
  assign carry_in = Cin;
`endif

  assign slice_a = a_reg[{idx, 2'b00} +: 4];
  assign slice_b = b_reg[{idx, 2'b00} +: 4];

  // The single shared slice: four full-adder cells rippling the carry.
  always_comb begin
    logic c;
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    slice_sum = '0;
    c         = carry;
    for (int k = 0; k < 4; k++) begin
      slice_sum[k] = slice_a[k] ^ slice_b[k] ^ c;
      c            = (slice_a[k] & slice_b[k]) | (slice_b[k] & c) | (c & slice_a[k]);
    end
    slice_cout = c;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, so nothing from an aborted operation survives.
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      Sum         <= '0;
      Cout        <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg       <= A;
            b_reg       <= b_in;
            carry       <= carry_in;
            idx         <= '0;
            Sum         <= '0;
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          Sum[{idx, 2'b00} +: 4] <= slice_sum;
          carry                  <= slice_cout;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            Cout      <= slice_cout;
            state     <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Retiring cycle returns to IDLE; a new request is only seen from the next cycle.
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomised self-checking bench for nibble_serial_add_ctrl against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_valid = 1'b0, start_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, op_sub = 1'b0;
  logic        busy, res_valid, res_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;

  logic        start_valid1 = 1'b0, start_ready1;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        cin1 = 1'b0, op_sub1 = 1'b0;
  logic        busy1, res_valid1, res_ready1 = 1'b0;
  logic [3:0]  sum1;
  logic        cout1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .A(a), .B(b), .Cin(cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .op_sub(op_sub),
`endif
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .Sum(sum), .Cout(cout)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid1), .start_ready(start_ready1),
    .A(a1), .B(b1), .Cin(cin1),
`ifdef NIBBLE_SERIAL_SUB_EN
    .op_sub(op_sub1),
`endif
    .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready1), .Sum(sum1), .Cout(cout1)
  );

  // Reference: W+1-bit arithmetic; subtract is A + (2^16-1-B) + 1.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic sub);
    if (sub) model = {1'b0, x} + {1'b0, 16'hFFFF - y} + 17'd1;
    else     model = {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Runs one request on the 4-nibble DUT starting at a falling edge; leaves it in DONE.
  task automatic run4(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs, output logic rdy, output logic [15:0] s,
                      output logic co, output int lat, output int bcyc);
    rdy = start_ready;
    start_valid = 1'b1; a = xa; b = xb; cin = xc; op_sub = xs; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0; bcyc = 0;
    while (!res_valid && lat < 40) begin
      if (busy) bcyc++;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout;
  endtask

  task automatic retire4();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready got %b want 1", start_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else pass_cnt++;
    total_cnt++; if ({sum, cout} !== 17'd0) $display("FAIL reset_sum_cout got %h/%b want 0/0", sum, cout); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic rdy, co; logic [15:0] s; int lat, bcyc;
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, rdy, s, co, lat, bcyc);
    total_cnt++; if (lat !== 4) $display("FAIL wrap_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if ({co, s} !== 17'h10000) $display("FAIL wrap_result got %b/%h want 1/0000", co, s); else pass_cnt++;
    retire4();
    run4(16'h1234, 16'h4321, 1'b1, 1'b0, rdy, s, co, lat, bcyc);
    total_cnt++; if (bcyc !== 4) $display("FAIL busy_cycles got %0d want 4", bcyc); else pass_cnt++;
    total_cnt++; if ({co, s} !== 17'h05556) $display("FAIL add_cin got %b/%h want 0/5556", co, s); else pass_cnt++;
    retire4();
  endtask

  task automatic test_random();
    logic rdy, co, xc; logic [15:0] s, xa, xb; logic [16:0] exp; int lat, bcyc;
    for (int n = 0; n < 25; n++) begin
      xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
      if (n % 5 == 0) xb = 16'hFFFF - xa;
      exp = model(xa, xb, xc, 1'b0);
      run4(xa, xb, xc, 1'b0, rdy, s, co, lat, bcyc);
      total_cnt++; if (rdy !== 1'b1) $display("FAIL rand_ready[%0d] got %b want 1", n, rdy); else pass_cnt++;
      total_cnt++; if (lat !== 4 || bcyc !== 4) $display("FAIL rand_timing[%0d] got lat %0d busy %0d want 4/4", n, lat, bcyc); else pass_cnt++;
      total_cnt++; if ({co, s} !== exp) $display("FAIL rand_result[%0d] got %b/%h want %b/%h", n, co, s, exp[16], exp[15:0]); else pass_cnt++;
      retire4();
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  task automatic test_hold();
    logic rdy, co; logic [15:0] s; int lat, bcyc; logic [16:0] exp;
    exp = model(16'hBEEF, 16'h1357, 1'b1, 1'b0);
    run4(16'hBEEF, 16'h1357, 1'b1, 1'b0, rdy, s, co, lat, bcyc);
    start_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || {cout, sum} !== exp)
        $display("FAIL hold[%0d] got rv %b sr %b %b/%h want 1 0 %b/%h", k, res_valid, start_ready, cout, sum, exp[16], exp[15:0]);
      else pass_cnt++;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total_cnt++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || {cout, sum} !== exp)
      $display("FAIL retire_no_capture got sr %b busy %b rv %b %b/%h want 1 0 0 %b/%h", start_ready, busy, res_valid, cout, sum, exp[16], exp[15:0]);
    else pass_cnt++;
    start_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || start_ready !== 1'b1) $display("FAIL idle_stays got busy %b sr %b want 0 1", busy, start_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic rdy, co; logic [15:0] s; int lat, bcyc;
    start_valid = 1'b1; a = 16'h7777; b = 16'h1111; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (sum !== 16'h0 || cout !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL midrun_reset got %h/%b rv %b busy %b sr %b want 0000/0 0 0 1", sum, cout, res_valid, busy, start_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run4(16'h0003, 16'h0004, 1'b0, 1'b0, rdy, s, co, lat, bcyc);
    total_cnt++; if ({co, s} !== 17'h00007 || lat !== 4) $display("FAIL after_reset got %b/%h lat %0d want 0/0007 4", co, s, lat); else pass_cnt++;
    retire4();
  endtask

  task automatic test_sub();
`ifdef NIBBLE_SERIAL_SUB_EN
    logic rdy, co; logic [15:0] s, xa, xb; logic [16:0] exp; int lat, bcyc;
    run4(16'h0005, 16'h0007, 1'b0, 1'b1, rdy, s, co, lat, bcyc);
    total_cnt++; if ({co, s} !== 17'h0FFFE) $display("FAIL sub_borrow got %b/%h want 0/FFFE", co, s); else pass_cnt++;
    retire4();
    run4(16'h0007, 16'h0005, 1'b0, 1'b1, rdy, s, co, lat, bcyc);
    total_cnt++; if ({co, s} !== 17'h10002) $display("FAIL sub_noborrow got %b/%h want 1/0002", co, s); else pass_cnt++;
    retire4();
    for (int n = 0; n < 6; n++) begin
      xa = 16'($urandom); xb = 16'($urandom);
      exp = model(xa, xb, 1'b0, 1'b1);
      run4(xa, xb, 1'($urandom), 1'b1, rdy, s, co, lat, bcyc);
      total_cnt++; if ({co, s} !== exp) $display("FAIL sub_rand[%0d] got %b/%h want %b/%h", n, co, s, exp[16], exp[15:0]); else pass_cnt++;
      retire4();
    end
`endif
    op_sub = 1'b0;
  endtask

  task automatic test_single_nibble();
    start_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid1 = 1'b0;
    total_cnt++; if (busy1 !== 1'b1 || res_valid1 !== 1'b0) $display("FAIL n1_run got busy %b rv %b want 1 0", busy1, res_valid1); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (res_valid1 !== 1'b1 || {cout1, sum1} !== 5'h11)
      $display("FAIL n1_result got rv %b %b/%h want 1 1/1", res_valid1, cout1, sum1);
    else pass_cnt++;
    res_ready1 = 1'b1;
    @(negedge clk);
    res_ready1 = 1'b0;
    total_cnt++; if (start_ready1 !== 1'b1 || res_valid1 !== 1'b0) $display("FAIL n1_retire got sr %b rv %b want 1 0", start_ready1, res_valid1); else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_run();
    test_sub();
    test_single_nibble();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
